fetch_prefetch_buffer: RTL and testbench

Parametrised successor to the single-FIFO fetch front end. Issues word-aligned instruction fetches with up to NUM_REQS outstanding on a req/gnt/rvalid bus and buffers responses in a FIFO_DEPTH-word queue. Realigns mixed 16/32-bit RISC-V instructions and delivers one instruction per cycle to decode over a valid/ready handshake. Handles redirects (branch/trap) with flush and discard of in-flight responses.

---
 rtl/fetch_prefetch_buffer.sv | 153 +++++++++++++++
 tb/tb_fetch_prefetch_buffer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch buffer with multiple outstanding bus requests.
// Fetched words are queued in a small shift FIFO. An aligner turns the head
// words into one 16- or 32-bit instruction per cycle for decode. A redirect
// flushes the queue, and responses that were already in flight are discarded.
module fetch_prefetch_buffer #(
  parameter int unsigned FIFO_DEPTH    = 3,
  parameter int unsigned NUM_REQS      = 2,
  parameter logic [31:0] PC_RESET      = 32'h0000_0000,
  parameter bit          COMPRESSED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  input  logic        instr_rvalid_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_pc_o,
  output logic        out_is_compressed_o,
  output logic        out_err_o,
  output logic        busy_o
);

  localparam int unsigned CW = $clog2(NUM_REQS + 1);
  localparam int unsigned OW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [31:0]   fifo_data   [FIFO_DEPTH];
  logic          fifo_err    [FIFO_DEPTH];
  logic [31:0]   fifo_data_n [FIFO_DEPTH];
  logic          fifo_err_n  [FIFO_DEPTH];
  logic [OW-1:0] occupancy, occupancy_n;
  logic [CW-1:0] outstanding, outstanding_n;
  logic [CW-1:0] discard, discard_n;
  logic [31:0]   fetch_addr, fetch_addr_n;
  logic [31:0]   pc, pc_n;
  logic [AW-1:0] wr_idx;

  logic        unaligned, is_comp, need_w1, w0_err;
  logic        have_w0, have_w1;
  logic [15:0] lo_half, hi_half;
  logic        accept, pop, push, bus_grant;

  // Requests are held off during reset. Otherwise, a request is made only
  // while the queue can hold every response that is already owed.
  assign instr_req_o = rstn && !redirect_i
                    && (outstanding < CW'(NUM_REQS))
                    && ((32'(occupancy) + 32'(outstanding)) < FIFO_DEPTH);

  assign instr_addr_o = fetch_addr;
  assign out_pc_o     = pc;
  assign busy_o       = (outstanding != '0);

  assign have_w0 = (occupancy != '0);
  assign have_w1 = (occupancy >= OW'(2));

  // Aligner: select the halfword at pc and decide whether the next word is needed.
  always_comb begin
    unaligned = COMPRESSED_EN && pc[1];
    w0_err    = fifo_err[0];
    lo_half   = unaligned ? fifo_data[0][31:16] : fifo_data[0][15:0];
    hi_half   = unaligned ? fifo_data[1][15:0]  : fifo_data[0][31:16];
    is_comp   = COMPRESSED_EN && !w0_err && (lo_half[1:0] != 2'b11);
    need_w1   = unaligned && !is_comp && !w0_err;
    out_valid_o         = need_w1 ? have_w1 : have_w0;
    out_is_compressed_o = is_comp;
    out_instr_o         = is_comp ? {16'h0000, lo_half} : {hi_half, lo_half};
    out_err_o           = w0_err || (need_w1 && fifo_err[1]);
  end

  // Handshake and queue control. A redirect overrides an accept in the same
  // cycle. A grant that races a withdrawn request still produces a response,
  // so it is counted.
  always_comb begin
    accept    = out_valid_o && out_ready_i && !redirect_i;
    pop       = accept && (unaligned || !is_comp);
    push      = instr_rvalid_i && (discard == '0) && !redirect_i;
    bus_grant = redirect_i ? instr_gnt_i : (instr_gnt_i && instr_req_o);
    wr_idx    = AW'(occupancy - OW'(pop));
  end

  // Next state for the counters, the fetch address and the decode PC.
  always_comb begin
    outstanding_n = outstanding + CW'(bus_grant) - CW'(instr_rvalid_i);
    discard_n     = discard;
    occupancy_n   = occupancy + OW'(push) - OW'(pop);
    fetch_addr_n  = fetch_addr;
    pc_n          = pc;
    if (redirect_i) begin
      discard_n    = outstanding_n;
      occupancy_n  = '0;
      fetch_addr_n = redirect_pc_i & ~32'd3;
      pc_n         = redirect_pc_i & ~32'd1;
    end else begin
      if (instr_rvalid_i && (discard != '0)) begin
        discard_n = discard - CW'(1);
      end
      if (instr_req_o && instr_gnt_i) begin
        fetch_addr_n = fetch_addr + 32'd4;
      end
      if (accept) begin
        pc_n = pc + (is_comp ? 32'd2 : 32'd4);
      end
    end
  end

  // Next state for the shift FIFO. The head sits in entry 0. On a pop the
  // entries shift down, and a response is written just above the survivors.
  always_comb begin
    fifo_data_n = fifo_data;
    fifo_err_n  = fifo_err;
    if (pop) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        fifo_data_n[i] = fifo_data[i+1];
        fifo_err_n[i]  = fifo_err[i+1];
      end
    end
    if (push) begin
      fifo_data_n[wr_idx] = instr_rdata_i;
      fifo_err_n[wr_idx]  = instr_err_i;
    end
  end

  // State registers. Reset drops the queue and every in-flight transaction.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occupancy   <= '0;
      outstanding <= '0;
      discard     <= '0;
      fetch_addr  <= PC_RESET & ~32'd3;
      pc          <= PC_RESET;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_err[i]  <= 1'b0;
      end
    end else begin
      occupancy   <= occupancy_n;
      outstanding <= outstanding_n;
      discard     <= discard_n;
      fetch_addr  <= fetch_addr_n;
      pc          <= pc_n;
      fifo_data   <= fifo_data_n;
      fifo_err    <= fifo_err_n;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Randomised self-checking bench for fetch_prefetch_buffer.
// The bench acts as the instruction memory. Its model tracks the decode PC,
// the fetch address, the counts of buffered and owed words, and the number of
// responses still to be discarded. It derives the expected instruction
// directly from the memory image at the PC.
module tb_fetch_prefetch_buffer;

  localparam int          FIFO_DEPTH = 3;
  localparam int          NUM_REQS   = 2;
  localparam logic [31:0] PC_RESET   = 32'h0000_0080;

  logic        clk, rstn;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_req_o, instr_gnt_i;
  logic [31:0] instr_addr_o, instr_rdata_i;
  logic        instr_err_i, instr_rvalid_i;
  logic        out_valid_o, out_ready_i;
  logic [31:0] out_instr_o, out_pc_o;
  logic        out_is_compressed_o, out_err_o, busy_o;

  fetch_prefetch_buffer #(
    .FIFO_DEPTH(FIFO_DEPTH), .NUM_REQS(NUM_REQS),
    .PC_RESET(PC_RESET), .COMPRESSED_EN(1'b1)
  ) dut (
    .clk(clk), .rstn(rstn),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i),
    .instr_addr_o(instr_addr_o), .instr_rdata_i(instr_rdata_i),
    .instr_err_i(instr_err_i), .instr_rvalid_i(instr_rvalid_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_instr_o(out_instr_o), .out_pc_o(out_pc_o),
    .out_is_compressed_o(out_is_compressed_o), .out_err_o(out_err_o),
    .busy_o(busy_o)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        comp;
    logic        err;
  } acc_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mem_img [logic [31:0]];
  bit          err_img [logic [31:0]];
  logic [31:0] bus_q [$];
  acc_t        acc_q [$];
  int          max_bus;

  logic [31:0] m_pc, m_faddr;
  int          m_out, m_disc, m_occ;
  logic        e_valid, e_comp, e_err;
  logic [31:0] e_instr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    if (mem_img.exists(a)) return mem_img[a];
    w = a * 32'h9E37_79B1;
    w = w ^ (w >> 15);
    w = w * 32'h85EB_CA6B;
    w = w ^ (w >> 13);
    if (w[20]) w[1:0] = 2'b11;
    if (w[21]) w[17:16] = 2'b11;
    return w;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    logic [31:0] e;
    if (err_img.exists(a)) return err_img[a];
    if (mem_img.exists(a)) return 1'b0;
    e = a * 32'h2545_F491;
    return (e[31:27] == 5'd0);
  endfunction

  function automatic logic [15:0] half_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word({a[31:2], 2'b00});
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_pc    = PC_RESET;
    m_faddr = PC_RESET & ~32'd3;
    m_out   = 0;
    m_disc  = 0;
    m_occ   = 0;
  endtask

  // Compare every DUT output with the model for the current cycle's inputs.
  task automatic checkOutput();
    logic [15:0] lo, hi;
    logic        w0err, is32, e_req;
    int          need;
    lo      = half_at(m_pc);
    hi      = half_at(m_pc + 32'd2);
    w0err   = mem_err({m_pc[31:2], 2'b00});
    is32    = (lo[1:0] == 2'b11) || w0err;
    need    = (m_pc[1] && is32 && !w0err) ? 2 : 1;
    e_valid = (m_occ >= need);
    e_comp  = !is32;
    e_instr = e_comp ? {16'h0000, lo} : {hi, lo};
    e_err   = w0err || ((need == 2) && mem_err({m_pc[31:2], 2'b00} + 32'd4));
    e_req   = !redirect_i && (m_out < NUM_REQS) && ((m_occ + m_out) < FIFO_DEPTH);
    cmp("instr_req", instr_req_o, e_req);
    cmp("instr_addr", instr_addr_o, m_faddr);
    cmp("out_pc", out_pc_o, m_pc);
    cmp("busy", busy_o, (m_out != 0));
    cmp("out_valid", out_valid_o, e_valid);
    if (e_valid) begin
      cmp("is_compressed", out_is_compressed_o, e_comp);
      cmp("out_err", out_err_o, e_err);
      if (!w0err) cmp("out_instr", out_instr_o, e_instr);
    end
  endtask

  // Advance the model by one clock edge, using the inputs applied in this cycle.
  task automatic modelStep(input logic redir, input logic [31:0] rpc, input logic rdy,
                           input logic g, input logic rv);
    logic acc;
    acc = e_valid && rdy && !redir;
    if (redir) begin
      m_out   = m_out + int'(g) - int'(rv);
      m_disc  = m_out;
      m_occ   = 0;
      m_pc    = rpc & ~32'd1;
      m_faddr = rpc & ~32'd3;
    end else begin
      if (acc) begin
        if (!(e_comp && !m_pc[1])) m_occ--;
        m_pc = m_pc + (e_comp ? 32'd2 : 32'd4);
      end
      if (g) begin
        m_faddr = m_faddr + 32'd4;
        m_out++;
      end
      if (rv) begin
        m_out--;
        if (m_disc > 0) m_disc--;
        else m_occ++;
      end
    end
  endtask

  // One bus/decode cycle. Inputs are driven after the falling edge, and
  // outputs are checked 2 time units later, before the next rising edge.
  task automatic applyStimulus(input logic redir, input logic [31:0] rpc, input logic rdy,
                               input int gnt_pct, input int rv_pct);
    logic [31:0] a;
    logic        g, rv;
    acc_t        rec;
    @(negedge clk);
    redirect_i    = redir;
    redirect_pc_i = rpc;
    out_ready_i   = rdy;
    rv            = 1'b0;
    if (bus_q.size() > 0 && $urandom_range(99) < rv_pct) begin
      a             = bus_q.pop_front();
      rv            = 1'b1;
      instr_rdata_i = mem_word(a);
      instr_err_i   = mem_err(a);
    end else begin
      instr_rdata_i = $urandom;
      instr_err_i   = 1'($urandom);
    end
    instr_rvalid_i = rv;
    #1;
    g           = instr_req_o && ($urandom_range(99) < gnt_pct);
    instr_gnt_i = g;
    #1;
    checkOutput();
    if (out_valid_o && rdy && !redir) begin
      rec.instr = out_instr_o;
      rec.pc    = out_pc_o;
      rec.comp  = out_is_compressed_o;
      rec.err   = out_err_o;
      acc_q.push_back(rec);
    end
    if (g) bus_q.push_back(instr_addr_o);
    if (bus_q.size() > max_bus) max_bus = bus_q.size();
    modelStep(redir, rpc, rdy, g, rv);
  endtask

  task automatic runUntil(input int n, input int max_cyc, input int gnt_pct, input int rv_pct);
    int c;
    c = 0;
    while (acc_q.size() < n && c < max_cyc) begin
      applyStimulus(1'b0, 32'h0, 1'b1, gnt_pct, rv_pct);
      c++;
    end
    n_vec++;
    if (acc_q.size() < n) begin
      n_err++;
      $display("[TB] FAIL accept_timeout: got %0d instructions, expected %0d", acc_q.size(), n);
    end
  endtask

  task automatic checkAcc(input int idx, input logic [31:0] instr, input logic [31:0] pc,
                          input logic comp, input logic err, input logic chk_instr);
    if (idx < acc_q.size()) begin
      if (chk_instr) cmp($sformatf("acc%0d_instr", idx), acc_q[idx].instr, instr);
      cmp($sformatf("acc%0d_pc", idx), acc_q[idx].pc, pc);
      cmp($sformatf("acc%0d_comp", idx), acc_q[idx].comp, comp);
      cmp($sformatf("acc%0d_err", idx), acc_q[idx].err, err);
    end
  endtask

  task automatic checkResetState();
    cmp("rst_req", instr_req_o, 1'b0);
    cmp("rst_addr", instr_addr_o, 32'h0000_0080);
    cmp("rst_pc", out_pc_o, 32'h0000_0080);
    cmp("rst_valid", out_valid_o, 1'b0);
    cmp("rst_busy", busy_o, 1'b0);
  endtask

  task automatic idleInputs();
    redirect_i     = 1'b0;
    redirect_pc_i  = 32'h0;
    instr_gnt_i    = 1'b0;
    instr_rdata_i  = 32'h0;
    instr_err_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    out_ready_i    = 1'b0;
  endtask

  initial begin
    int          c, rdy_pct;
    logic        redir;
    logic [31:0] rpc;

    rstn = 1'b0;
    idleInputs();
    modelReset();
    mem_img[32'h80]  = 32'h0000_0013;
    mem_img[32'h84]  = 32'h0000_0013;
    mem_img[32'h88]  = 32'h0000_0013;
    mem_img[32'h100] = 32'h4505_0513;
    mem_img[32'h104] = 32'h4585_4501;
    mem_img[32'h108] = 32'h0000_0013;
    mem_img[32'h200] = 32'h0513_1234;
    mem_img[32'h204] = 32'hABCD_0000;
    mem_img[32'h400] = 32'h00A0_0093;
    mem_img[32'h500] = 32'hDEAD_BEEF;
    err_img[32'h500] = 1'b1;
    mem_img[32'h504] = 32'h0000_0013;

    repeat (2) @(negedge clk);
    #1;
    checkResetState();
    @(negedge clk);
    rstn = 1'b1;

    // Zero-wait memory from reset release
    acc_q.delete();
    max_bus = 0;
    runUntil(3, 40, 100, 100);
    checkAcc(0, 32'h0000_0013, 32'h80, 1'b0, 1'b0, 1'b1);
    checkAcc(1, 32'h0000_0013, 32'h84, 1'b0, 1'b0, 1'b1);
    checkAcc(2, 32'h0000_0013, 32'h88, 1'b0, 1'b0, 1'b1);
    cmp("max_outstanding_le_2", (max_bus <= 2), 1'b1);

    // Mixed 32/16-bit stream
    acc_q.delete();
    applyStimulus(1'b1, 32'h100, 1'b1, 100, 100);
    runUntil(4, 60, 100, 100);
    checkAcc(0, 32'h4505_0513, 32'h100, 1'b0, 1'b0, 1'b1);
    checkAcc(1, 32'h0000_4501, 32'h104, 1'b1, 1'b0, 1'b1);
    checkAcc(2, 32'h0000_4585, 32'h106, 1'b1, 1'b0, 1'b1);
    checkAcc(3, 32'h0000_0013, 32'h108, 1'b0, 1'b0, 1'b1);

    // Unaligned 32-bit instruction split across two words
    acc_q.delete();
    applyStimulus(1'b1, 32'h202, 1'b1, 100, 50);
    runUntil(2, 60, 100, 50);
    checkAcc(0, 32'h0000_0513, 32'h202, 1'b0, 1'b0, 1'b1);
    if (acc_q.size() > 1) cmp("split_next_pc", acc_q[1].pc, 32'h206);

    // Redirect with two requests outstanding and a response in the same cycle
    c = 0;
    while (bus_q.size() > 0 && c < 20) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 0, 100);
      c++;
    end
    cmp("bus_drained", bus_q.size(), 0);
    applyStimulus(1'b1, 32'h300, 1'b1, 0, 0);
    applyStimulus(1'b0, 32'h0, 1'b1, 100, 0);
    applyStimulus(1'b0, 32'h0, 1'b1, 100, 0);
    cmp("two_outstanding", bus_q.size(), 2);
    cmp("busy_two_out", busy_o, 1'b1);
    acc_q.delete();
    applyStimulus(1'b1, 32'h400, 1'b1, 100, 100);
    cmp("redirect_req_low", instr_req_o, 1'b0);
    runUntil(1, 40, 100, 100);
    checkAcc(0, 32'h00A0_0093, 32'h400, 1'b0, 1'b0, 1'b1);

    // Decode stall fills the FIFO, then drains in order
    acc_q.delete();
    applyStimulus(1'b1, 32'h600, 1'b0, 100, 100);
    repeat (10) applyStimulus(1'b0, 32'h0, 1'b0, 100, 100);
    cmp("stall_req_low", instr_req_o, 1'b0);
    cmp("stall_valid", out_valid_o, 1'b1);
    cmp("stall_pc_held", out_pc_o, 32'h600);
    runUntil(6, 80, 100, 100);
    if (acc_q.size() > 0) cmp("drain_first_pc", acc_q[0].pc, 32'h600);

    // Bus error on the word at 0x500
    acc_q.delete();
    applyStimulus(1'b1, 32'h500, 1'b1, 100, 100);
    runUntil(2, 60, 100, 100);
    checkAcc(0, 32'h0, 32'h500, 1'b0, 1'b1, 1'b0);
    checkAcc(1, 32'h0000_0013, 32'h504, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of traffic
    applyStimulus(1'b1, 32'h700, 1'b1, 100, 100);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 100, 0);
    @(negedge clk);
    rstn = 1'b0;
    idleInputs();
    #1;
    checkResetState();
    bus_q.delete();
    modelReset();
    @(negedge clk);
    rstn = 1'b1;

    // Random traffic with redirects, stalls and address wrap
    rdy_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(2))
          0:       rdy_pct = 30;
          1:       rdy_pct = 70;
          default: rdy_pct = 100;
        endcase
      end
      redir = ($urandom_range(99) < 3);
      if ($urandom_range(9) == 0) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(15));
      else                        rpc = 32'h1000 + 32'($urandom_range(4095));
      applyStimulus(redir, rpc, ($urandom_range(99) < rdy_pct), 70, 60);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
